// File: rtl/ifu_fetch_if.sv
// Bus bundles for the fetch unit: instruction-memory port and IDU handoff port.
// master = fetch unit side, slave = memory / IDU side.
interface ifu_imem_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;

  modport master (
    output req_valid, req_addr,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

interface ifu_inst_if;
  logic        valid;
  logic        ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        err;

  modport master (
    output valid, inst, pc, err,
    input  ready
  );

  modport slave (
    input  valid, inst, pc, err,
    output ready
  );
endinterface

// File: rtl/ifu_fetch.sv
// Non-pipelined instruction fetch: one word read per instruction, held for the
// IDU, then waits for writeback to supply the next PC.
//
// state  | meaning
// IDLE   | post-reset, moves to REQ next cycle
// REQ    | issue fetch of pc (or flag misaligned pc)
// WAIT   | request accepted, waiting for response
// HOLD   | instruction presented to IDU until inst_ready
// WAITPC | waiting for writeback to supply next pc
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  ifu_imem_if.master  imem,
  ifu_inst_if.master  idu,
  input  logic        nxt_valid,
  input  logic [31:0] nxt_pc,
  output logic [31:0] pc,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    HOLD   = 3'd3,
    WAITPC = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q;
  logic [31:0] cnt_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        inst_err_q;

  logic        misaligned;
  logic        ld_fault;
  logic        ld_resp;
  logic        cnt_inc;
  logic        ld_pc;

  assign misaligned = |pc_q[1:0];

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_fault  = 1'b0;
    ld_resp   = 1'b0;
    cnt_inc   = 1'b0;
    ld_pc     = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (misaligned) begin
          ld_fault  = 1'b1;
          state_nxt = HOLD;
        end else if (imem.req_ready) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem.resp_valid) begin
          ld_resp   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (idu.ready) begin
          cnt_inc   = 1'b1;
          state_nxt = WAITPC;
        end
      end
      WAITPC: begin
        if (nxt_valid) begin
          ld_pc     = 1'b1;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      pc_q       <= RESET_PC;
      cnt_q      <= 32'd0;
      inst_q     <= 32'd0;
      inst_pc_q  <= 32'd0;
      inst_err_q <= 1'b0;
    end else begin
      if (ld_pc) pc_q <= nxt_pc;
      if (cnt_inc) cnt_q <= cnt_q + 32'd1;
      // a misaligned pc never reaches memory; it is reported as a faulting zero word
      if (ld_fault) begin
        inst_q     <= 32'd0;
        inst_pc_q  <= pc_q;
        inst_err_q <= 1'b1;
      end else if (ld_resp) begin
        inst_q     <= imem.resp_data;
        inst_pc_q  <= pc_q;
        inst_err_q <= imem.resp_err;
      end
    end
  end

  // handshake valids depend only on registered state, never on inputs
  assign imem.req_valid = (state == REQ) && !misaligned;
  assign imem.req_addr  = pc_q;
  assign idu.valid      = (state == HOLD);
  assign idu.inst       = inst_q;
  assign idu.pc         = inst_pc_q;
  assign idu.err        = inst_err_q;
  assign pc             = pc_q;
  assign fetch_cnt      = cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed + randomized bench for ifu_fetch with a transaction-level expectation
// of pc, fetch count and delivered instruction payload.
module tb_ifu_fetch;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        nxt_valid;
  logic [31:0] nxt_pc;
  logic [31:0] pc;
  logic [31:0] fetch_cnt;

  ifu_imem_if imem_bus ();
  ifu_inst_if inst_bus ();

  ifu_fetch #(.RESET_PC(RESET_PC)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .imem      (imem_bus),
    .idu       (inst_bus),
    .nxt_valid (nxt_valid),
    .nxt_pc    (nxt_pc),
    .pc        (pc),
    .fetch_cnt (fetch_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic idle_inputs();
    imem_bus.req_ready  = 1'b0;
    imem_bus.resp_valid = 1'b0;
    imem_bus.resp_data  = 32'd0;
    imem_bus.resp_err   = 1'b0;
    inst_bus.ready      = 1'b0;
    nxt_valid           = 1'b0;
    nxt_pc              = 32'd0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pc"},        pc, RESET_PC);
    check({tag, "_req_valid"}, imem_bus.req_valid, 32'd0);
    check({tag, "_req_addr"},  imem_bus.req_addr, RESET_PC);
    check({tag, "_inst_valid"}, inst_bus.valid, 32'd0);
    check({tag, "_inst"},      inst_bus.inst, 32'd0);
    check({tag, "_inst_pc"},   inst_bus.pc, 32'd0);
    check({tag, "_inst_err"},  inst_bus.err, 32'd0);
    check({tag, "_fetch_cnt"}, fetch_cnt, 32'd0);
  endtask

  // One instruction from REQ through the IDU handshake; ends in WAITPC.
  task automatic fetch(input int req_stall, input int lat, input logic [31:0] data,
                       input logic rerr, input int hold_stall, input bit hold_nxt);
    logic [31:0] exp_inst;
    logic        exp_err;
    int          guard;
    if (exp_pc[1:0] == 2'b00) begin
      guard = 0;
      while (imem_bus.req_valid !== 1'b1 && guard < 8) begin
        tick();
        guard++;
      end
      check("req_valid", imem_bus.req_valid, 32'd1);
      for (int i = 0; i < req_stall; i++) begin
        check("req_addr_stall", imem_bus.req_addr, exp_pc);
        check("req_valid_stall", imem_bus.req_valid, 32'd1);
        tick();
      end
      check("req_addr", imem_bus.req_addr, exp_pc);
      imem_bus.req_ready = 1'b1;
      tick();
      imem_bus.req_ready = 1'b0;
      check("single_req", imem_bus.req_valid, 32'd0);
      for (int i = 0; i < lat; i++) begin
        check("wait_no_inst", inst_bus.valid, 32'd0);
        tick();
      end
      imem_bus.resp_valid = 1'b1;
      imem_bus.resp_data  = data;
      imem_bus.resp_err   = rerr;
      tick();
      imem_bus.resp_valid = 1'b0;
      imem_bus.resp_data  = $urandom;
      imem_bus.resp_err   = 1'b0;
      exp_inst = data;
      exp_err  = rerr;
    end else begin
      check("misalign_no_req", imem_bus.req_valid, 32'd0);
      tick();
      exp_inst = 32'd0;
      exp_err  = 1'b1;
    end
    for (int i = 0; i <= hold_stall; i++) begin
      check("inst_valid", inst_bus.valid, 32'd1);
      check("inst", inst_bus.inst, exp_inst);
      check("inst_pc", inst_bus.pc, exp_pc);
      check("inst_err", inst_bus.err, {31'd0, exp_err});
      if (i < hold_stall) begin
        if (hold_nxt && i == 0) begin
          nxt_valid = 1'b1;
          nxt_pc    = $urandom;
        end
        if (i == 1) begin
          imem_bus.resp_valid = 1'b1;
          imem_bus.resp_data  = $urandom;
          imem_bus.resp_err   = 1'b1;
        end
        tick();
        nxt_valid           = 1'b0;
        imem_bus.resp_valid = 1'b0;
        imem_bus.resp_err   = 1'b0;
      end
    end
    inst_bus.ready = 1'b1;
    tick();
    inst_bus.ready = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
    check("fetch_cnt", fetch_cnt, exp_cnt);
    check("inst_valid_drop", inst_bus.valid, 32'd0);
    check("pc_hold", pc, exp_pc);
  endtask

  // Writeback returns the next pc after some idle cycles in WAITPC.
  task automatic redirect(input logic [31:0] npc, input int delay);
    for (int i = 0; i < delay; i++) begin
      check("waitpc_quiet", {imem_bus.req_valid, inst_bus.valid}, 32'd0);
      if (i == 0) begin
        imem_bus.resp_valid = 1'b1;
        imem_bus.resp_data  = $urandom;
      end
      tick();
      imem_bus.resp_valid = 1'b0;
    end
    nxt_valid = 1'b1;
    nxt_pc    = npc;
    tick();
    nxt_valid = 1'b0;
    nxt_pc    = $urandom;
    exp_pc    = npc;
    check("pc_redirect", pc, exp_pc);
    check("turnaround_req", imem_bus.req_valid, {31'd0, (npc[1:0] == 2'b00)});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] npc;
    idle_inputs();
    exp_pc  = RESET_PC;
    exp_cnt = 32'd0;
    repeat (2) tick();
    check_reset("rst");

    sys_rst = 1'b1;
    check("idle_no_req", imem_bus.req_valid, 32'd0);
    tick();
    check("cycle1_req_valid", imem_bus.req_valid, 32'd1);
    check("cycle1_req_addr", imem_bus.req_addr, RESET_PC);

    fetch(0, 0, 32'h0000_0093, 1'b0, 0, 1'b0);
    redirect(32'h8000_0100, 1);
    fetch(4, 1, $urandom, 1'b0, 5, 1'b1);
    redirect(32'h8000_0102, 0);
    fetch(0, 0, 32'd0, 1'b0, 2, 1'b0);
    redirect(32'h8000_0200, 2);
    fetch(0, 2, $urandom, 1'b1, 1, 1'b0);

    for (int n = 0; n < 24; n++) begin
      npc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 4) == 0) npc[1:0] = 2'($urandom_range(1, 3));
      redirect(npc, $urandom_range(0, 3));
      fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom,
            ($urandom_range(0, 3) == 0), $urandom_range(0, 3), ($urandom_range(0, 1) == 1));
    end

    // reset while a request is outstanding, then a stale response after release
    redirect(32'h8000_0400, 0);
    imem_bus.req_ready = 1'b1;
    tick();
    imem_bus.req_ready = 1'b0;
    #2 sys_rst = 1'b0;
    #1 check_reset("async_rst");
    tick();
    tick();
    sys_rst = 1'b1;
    exp_pc  = RESET_PC;
    exp_cnt = 32'd0;
    imem_bus.resp_valid = 1'b1;
    imem_bus.resp_data  = 32'hDEAD_BEEF;
    imem_bus.resp_err   = 1'b1;
    tick();
    check("stale_req_valid", imem_bus.req_valid, 32'd1);
    check("stale_req_addr", imem_bus.req_addr, RESET_PC);
    tick();
    imem_bus.resp_valid = 1'b0;
    imem_bus.resp_err   = 1'b0;
    check("stale_inst", inst_bus.inst, 32'd0);
    check("stale_inst_valid", inst_bus.valid, 32'd0);
    check("stale_inst_err", inst_bus.err, 32'd0);
    fetch(0, 1, 32'h0000_0013, 1'b0, 0, 1'b0);

    // counter wrap
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1 release dut.cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    check("cnt_preload", fetch_cnt, exp_cnt);
    redirect(RESET_PC + 32'd4, 1);
    fetch(1, 0, $urandom, 1'b0, 1, 1'b0);
    check("cnt_wrap", fetch_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Multi-cycle instruction fetch unit sitting directly upstream of the IDU. Owns the architectural PC, issues one word read per instruction over a valid/ready request and valid response instruction-memory port, and holds the fetched instruction on a valid/ready handshake toward the IDU. It then waits for the writeback stage to return the next PC before fetching again. The design is strictly non-pipelined, with one instruction in flight.

## Interface
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- sys_clk  input  1  clock; all state updates on the rising edge.
- sys_rst  input  1  asynchronous, active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_req_addr  output  32  word address of the fetch; equals pc.
- imem_resp_valid  input  1  response data valid, one cycle per accepted request.
- imem_resp_data  input  32  fetched instruction word.
- imem_resp_err  input  1  access fault for this response.
- inst_valid  output  1  instruction available to the IDU.
- inst_ready  input  1  IDU consumes the instruction.
- inst  output  32  instruction word.
- inst_pc  output  32  PC of inst.
- inst_err  output  1  fetch fault (misaligned or access error).
- nxt_valid  input  1  writeback has retired and supplies the next PC.
- nxt_pc  input  32  next PC.
- pc  output  32  current PC register.
- fetch_cnt  output  32  count of instructions handed to the IDU.

## Operation
- States: IDLE, REQ, WAIT, HOLD, WAITPC. The state register resets to IDLE.
- IDLE always moves to REQ on the next cycle.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - If pc[1:0]!=0, no request is issued: imem_req_valid=0, inst<=0, inst_err<=1, state moves to HOLD.
  - Otherwise, when imem_req_ready=1, state moves to WAIT.
  - imem_req_addr is held stable while stalled.
- WAIT:
  - On imem_resp_valid, capture inst<=imem_resp_data, inst_err<=imem_resp_err, inst_pc<=pc, then move to HOLD.
  - A response with err=1 still captures the data; downstream handles the trap.
- HOLD:
  - inst_valid=1. inst, inst_pc and inst_err stay stable until inst_ready=1.
  - On handshake: fetch_cnt<=fetch_cnt+1 (mod 2^32, wraps to 0), then move to WAITPC.
- WAITPC: on nxt_valid, pc<=nxt_pc and state moves to REQ. nxt_pc is not masked; misalignment is caught in REQ.
- imem_resp_valid outside WAIT is ignored. This covers stale responses after a mid-operation reset.
- nxt_valid outside WAITPC is ignored.
- imem_req_valid and inst_valid are decoded from the state register only. They have no combinational path from any input.

## Timing
- During reset (sys_rst=0):
  - pc=RESET_PC, state=IDLE.
  - imem_req_valid=0, inst_valid=0.
  - inst=0, inst_pc=0, inst_err=0, fetch_cnt=0.
  - imem_req_addr=RESET_PC.
- Reset asserted in any state forces reset values immediately and asynchronously. An in-flight request is abandoned.
- Cycle 0 is the first edge after release: IDLE to REQ.
  - Cycle 1: imem_req_valid=1.
  - With ready=1 and a response on cycle 2, inst_valid=1 from cycle 3.
- Minimum turnaround from nxt_valid (cycle n) to the next imem_req_valid is cycle n+1.
- The response is accepted no earlier than the cycle after request acceptance.
- A misaligned PC goes from REQ to HOLD in one cycle: inst_valid is asserted the following cycle.
- Back-pressure: inst_valid stays high indefinitely with unchanged payload while inst_ready=0.
- fetch_cnt updates on the edge of the inst handshake and is visible the next cycle.

## Test plan
- Reset, then memory with ready=1 and 1-cycle latency returning 32'h0000_0093 -> imem_req_addr=32'h8000_0000 at cycle 1; inst_valid=1 at cycle 3 with inst=32'h0000_0093, inst_pc=32'h8000_0000, inst_err=0; fetch_cnt=1 after handshake.
- Back-pressure and stall: imem_req_ready low for 4 cycles, inst_ready low for 5 cycles -> request address stable, single request accepted; inst payload constant; exactly one fetch_cnt increment.
- Redirect: nxt_valid with nxt_pc=32'h8000_0100 in WAITPC -> next request addr 32'h8000_0100. A nxt_valid pulse during HOLD is ignored (pc unchanged).
- Faults:
  - nxt_pc=32'h8000_0102 -> no imem_req_valid; inst_valid with inst_err=1, inst_pc=32'h8000_0102.
  - Response with imem_resp_err=1 -> inst_err=1.
- Reset mid-WAIT, then a stale imem_resp_valid right after release -> ignored. Outputs return to reset values; fresh fetch from RESET_PC.
- Preload fetch_cnt to 32'hFFFF_FFFF via 2^32 handshakes in a forced-state bench (or a hierarchical force) -> the next handshake wraps fetch_cnt to 0.
